// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding, mode constants and default geometry for mem_burst_interface
// PAR_W is the extra stored bit per word when MEM_PARITY_EN is defined, else 0.
package mem_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_READ, S_FLUSH, S_DONE} state_t;
  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_DEPTH   = 2048;
  localparam int DEF_BURST_W = 4;
`ifdef MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
endpackage

// File: rtl/sram_array.sv
// sram_array: DEPTH x WIDTH storage, synchronous write, registered read
// Ports: clk; we/waddr/wdata write port; raddr in, rdata = mem[raddr] as of the last edge.
module sram_array #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/mem_burst_interface.sv
// mem_burst_interface: MAR/MDR burst memory interface with req/busy/done handshake and tri-state data bus
// Ports: clk, rst (sync, active-high); req/nWrite/addr/burst_len sampled in IDLE;
//   mem_data shared bus (driven only while rd_valid); busy, wr_ready, rd_valid, done, addr_err status;
//   par_err (only when MEM_PARITY_EN is defined) flags a read beat whose stored parity mismatches.
module mem_burst_interface
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               nWrite,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               wr_ready,
  output logic               rd_valid,
  output logic               done,
  output logic               addr_err,
`ifdef MEM_PARITY_EN
  output logic               par_err,
`endif
  inout  wire  [DATA_W-1:0]  mem_data
);
  localparam int W = DATA_W + PAR_W;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d, mar_nxt;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [W-1:0] mdr_q, mdr_d, rdata, wdata;
  logic mode_q, mode_d, err_q, err_d, rd_valid_q, rd_valid_d, we;
  assign mar_nxt = (mar_q == ADDR_W'(DEPTH - 1)) ? '0 : mar_q + 1'b1;
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    mdr_d   = mdr_q;
    we      = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = S_LOAD;
        mar_d   = addr;
        cnt_d   = burst_len;
        mode_d  = nWrite;
        err_d   = 1'b0;
      end
      S_LOAD: begin
        err_d   = 32'(mar_q) >= DEPTH;
        state_d = err_d ? S_DONE : (mode_q == MODE_READ ? S_READ : S_WRITE);
      end
      S_WRITE: begin
        we      = 1'b1;
        mar_d   = mar_nxt;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? S_DONE : S_WRITE;
      end
      S_READ: begin
        mdr_d   = rdata;
        mar_d   = mar_nxt;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? S_FLUSH : S_READ;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // Every READ cycle but the first is preceded by a READ, as is FLUSH: exactly the valid beats.
  assign rd_valid_d = (state_q == S_READ);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mar_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= MODE_WRITE;
      err_q      <= 1'b0;
      mdr_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      mdr_q      <= mdr_d;
      rd_valid_q <= rd_valid_d;
    end
  end
`ifdef MEM_PARITY_EN
  assign wdata   = {^mem_data, mem_data};
  assign par_err = rd_valid_q & (^mdr_q);
`else
  assign wdata = mem_data;
`endif
  // Reading at the next MAR lets the registered array output line up with MDR capture.
  sram_array #(.WIDTH(W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_sram (
    .clk(clk), .we(we), .waddr(mar_q), .wdata(wdata), .raddr(mar_d), .rdata(rdata)
  );
  assign busy     = (state_q != S_IDLE);
  assign wr_ready = (state_q == S_WRITE);
  assign rd_valid = rd_valid_q;
  assign done     = (state_q == S_DONE);
  assign addr_err = done & err_q;
  assign mem_data = rd_valid_q ? mdr_q[DATA_W-1:0] : 'z;
endmodule
